// File: rtl/imem_loader.sv
// UART (8N1) boot loader: streams a length-prefixed little-endian image into instruction memory, then releases the CPU.
// Optional trailing 8-bit checksum byte is enabled with `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int CLK_DIV     = 868,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        rx,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        cpu_run,
   output logic        busy,
   output logic        err,
   output logic [4:0]  dbg_state
);

   typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_t;
   typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERROR} ld_state_t;

   localparam int              CW      = $clog2(CLK_DIV);
   localparam logic [CW-1:0]   HALF_M1 = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0]   FULL_M1 = CW'(CLK_DIV - 1);
   localparam logic [16:0]     DEPTH_L = 17'(DEPTH_WORDS);

   rx_state_t     rx_state_q, rx_state_d;
   ld_state_t     ld_state_q, ld_state_d;
   logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
   logic [15:0]   len_q, len_d, word_idx_q, word_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [23:0]   buf_q, buf_d;
   logic          imem_we_q, imem_we_d;
   logic [31:0]   waddr_q, waddr_d, wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= R_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         ld_state_q   <= L_LEN0;
         len_q        <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         buf_q        <= '0;
         imem_we_q    <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         rx_s1_q      <= rx_s1_d;
         rx_s2_q      <= rx_s2_d;
         rx_prev_q    <= rx_prev_d;
         rx_state_q   <= rx_state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         ld_state_q   <= ld_state_d;
         len_q        <= len_d;
         word_idx_q   <= word_idx_d;
         byte_idx_q   <= byte_idx_d;
         buf_q        <= buf_d;
         imem_we_q    <= imem_we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   // Receiver: start bit is re-checked at mid-bit, then every later sample lands mid-bit.
   always_comb begin
      rx_s1_d      = rx;
      rx_s2_d      = rx_s1_q;
      rx_prev_d    = rx_s2_q;
      rx_state_d   = rx_state_q;
      cnt_d        = cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = R_START;
               cnt_d      = '0;
            end
         end
         R_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d      = '0;
               bit_idx_d  = '0;
               rx_state_d = rx_s2_q ? R_IDLE : R_BITS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_BITS: begin
            if (cnt_q == FULL_M1) begin
               cnt_d     = '0;
               shift_d   = {rx_s2_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d        = '0;
               byte_valid_d = rx_s2_q;
               frame_err_d  = !rx_s2_q;
               rx_state_d   = R_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // Loader: completion is taken in the strobe cycle so cpu_run never overlaps imem_we.
   always_comb begin
      ld_state_d = ld_state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      buf_d      = buf_q;
      imem_we_d  = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif
      if (frame_err_q && (ld_state_q inside {L_LEN0, L_LEN1, L_DATA, L_CSUM})) begin
         ld_state_d = L_ERROR;
      end else begin
         case (ld_state_q)
            L_LEN0: begin
               if (byte_valid_q) begin
                  len_d      = {8'h00, shift_q};
                  ld_state_d = L_LEN1;
               end
            end
            L_LEN1: begin
               if (byte_valid_q) begin
                  len_d = {shift_q, len_q[7:0]};
                  if ({1'b0, shift_q, len_q[7:0]} > DEPTH_L) ld_state_d = L_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  else if ({shift_q, len_q[7:0]} == 16'h0000) ld_state_d = L_CSUM;
`else
                  else if ({shift_q, len_q[7:0]} == 16'h0000) ld_state_d = L_DONE;
`endif
                  else ld_state_d = L_DATA;
               end
            end
            L_DATA: begin
               if (imem_we_q && (word_idx_q == len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  ld_state_d = L_CSUM;
`else
                  ld_state_d = L_DONE;
`endif
               end else if (byte_valid_q) begin
                  buf_d      = {shift_q, buf_q[23:8]};
                  byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum_d      = sum_q + shift_q;
`endif
                  if (byte_idx_q == 2'd3) begin
                     imem_we_d  = 1'b1;
                     waddr_d    = {14'b0, word_idx_q, 2'b00};
                     wdata_d    = {shift_q, buf_q};
                     word_idx_d = word_idx_q + 16'd1;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            L_CSUM: begin
               if (byte_valid_q) ld_state_d = (shift_q == sum_q) ? L_DONE : L_ERROR;
            end
`endif
            default: ;
         endcase
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign cpu_run    = (ld_state_q == L_DONE);
   assign err        = (ld_state_q == L_ERROR);
   assign busy       = ld_state_q inside {L_LEN1, L_DATA, L_CSUM};
   assign dbg_state  = {rx_state_q, ld_state_q};

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios with random image words, plus false-start and mid-load reset sequences.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;
   localparam int CLK_DIV = 16;
   localparam int DEPTH   = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        imem_we, cpu_run, busy, err;
   logic [31:0] imem_waddr, imem_wdata;
   logic [4:0]  dbg_state;

   imem_loader #(.CLK_DIV(CLK_DIV), .DEPTH_WORDS(DEPTH)) dut (
      .CLK(clk), .RST(rst_n), .rx(rx),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .cpu_run(cpu_run), .busy(busy), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [63:0] exp_q[$];  // {byte address, word} of every strobe still owed
   int          cyc = 0, last_we_cyc = 0, run_rise_cyc = 0;
   logic        run_prev = 1'b0;

   typedef struct {
      logic [15:0] len;
      int          bad_idx;   // stream byte sent with a low stop bit, -1 for none
      bit          bad_csum;
      bit          fixed;     // use the reference two-word program
      bit          exp_err;
      bit          exp_run;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      logic [63:0] e;
      cyc++;
      if (imem_we) begin
         check("run_during_we", 32'(cpu_run), 32'd0);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, want no strobe", imem_waddr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("waddr", imem_waddr, e[63:32]);
            check("wdata", imem_wdata, e[31:0]);
         end
         last_we_cyc = cyc;
      end
      if (cpu_run && !run_prev) run_rise_cyc = cyc;
      run_prev = cpu_run;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rx    = 1'b1;
      rst_n = 1'b0;
      exp_q.delete();
      step(3);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_waddr", imem_waddr, 32'd0);
      check("rst_wdata", imem_wdata, 32'd0);
      check("rst_run", 32'(cpu_run), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step(2);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx = 1'b0;
      step(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         step(CLK_DIV);
      end
      rx = ~bad_stop;
      step(CLK_DIV);
      rx = 1'b1;
   endtask

   // Reference model: words go to 4*k in order; a word is written only if all four of its bytes
   // arrive before any corrupted byte; the checksum is the mod-256 sum of the data bytes.
   task automatic run_load(input string tag, input logic [15:0] len, input int bad_idx,
                           input bit bad_csum, input bit fixed, input bit exp_err,
                           input bit exp_run, input bit with_reset);
      logic [7:0]  stream[$];
      logic [31:0] words[$];
      logic [31:0] plan_w[2];
      logic [31:0] w;
      logic [7:0]  sum;
      int          n_words;
      int          t;
      plan_w[0] = 32'h0010_0513;
      plan_w[1] = 32'h0020_0593;
      if (with_reset) do_reset();
      stream.push_back(len[7:0]);
      stream.push_back(len[15:8]);
      n_words = (len > DEPTH) ? 0 : int'(len);
      sum = 8'h00;
      for (int k = 0; k < n_words; k++) begin
         w = (fixed && k < 2) ? plan_w[k] : $urandom();
         words.push_back(w);
         for (int b = 0; b < 4; b++) begin
            stream.push_back(w[8*b +: 8]);
            sum = sum + w[8*b +: 8];
         end
         if (bad_idx < 0 || 4 * k + 5 < bad_idx) exp_q.push_back({32'(4 * k), w});
      end
      if (CSUM_EN && len <= DEPTH) stream.push_back(bad_csum ? sum + 8'd1 : sum);
      for (int i = 0; i < stream.size(); i++) begin
         if (bad_idx >= 0 && i > bad_idx) break;
         send_byte(stream[i], i == bad_idx);
         if (i == 0 && bad_idx != 0) check({tag, "_busy_after_len0"}, 32'(busy), 32'd1);
         if ($urandom_range(0, 2) != 0) step($urandom_range(1, 20));
      end
      for (t = 0; t < 64; t++) begin
         if (cpu_run || err) break;
         step(1);
      end
      check({tag, "_terminal_in_bound"}, 32'(t < 64), 32'd1);
      repeat (3) @(negedge clk);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_run));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (exp_run && n_words > 0) check({tag, "_run_latency"}, 32'(run_rise_cyc - last_we_cyc), 32'd1);
`endif
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[10];
      logic [31:0] w0;
      tbl[0] = '{16'd2,      -1, 1'b0, 1'b1, 1'b0,    1'b1};
      tbl[1] = '{16'd0,      -1, 1'b0, 1'b0, 1'b0,    1'b1};
      tbl[2] = '{16'd17,     -1, 1'b0, 1'b0, 1'b1,    1'b0};
      tbl[3] = '{16'd16,     -1, 1'b0, 1'b0, 1'b0,    1'b1};
      tbl[4] = '{16'd1,       2, 1'b0, 1'b0, 1'b1,    1'b0};
      tbl[5] = '{16'd3,      13, 1'b0, 1'b0, 1'b1,    1'b0};
      tbl[6] = '{16'd3,      -1, 1'b0, 1'b0, 1'b0,    1'b1};
      tbl[7] = '{16'd1,       0, 1'b0, 1'b0, 1'b1,    1'b0};
      tbl[8] = '{16'h0100,   -1, 1'b0, 1'b0, 1'b1,    1'b0};
      tbl[9] = '{16'd2,      -1, 1'b1, 1'b1, CSUM_EN, !CSUM_EN};

      for (int v = 0; v < 10; v++)
         run_load($sformatf("vec%0d", v), tbl[v].len, tbl[v].bad_idx, tbl[v].bad_csum,
                  tbl[v].fixed, tbl[v].exp_err, tbl[v].exp_run, 1'b1);

      for (int r = 0; r < 4; r++)
         run_load($sformatf("rand%0d", r), 16'($urandom_range(0, 6)), -1, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b1);

      // A 4-clock low glitch must die in the start-bit check.
      do_reset();
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      step(3 * CLK_DIV);
      check("glitch_busy", 32'(busy), 32'd0);
      check("glitch_err", 32'(err), 32'd0);
      run_load("after_glitch", 16'd0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset after five bytes of a two-word load, then a clean reload.
      do_reset();
      w0 = $urandom();
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      for (int b = 0; b < 3; b++) send_byte(w0[8*b +: 8], 1'b0);
      step(4);
      check("midload_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midload_rst_we", 32'(imem_we), 32'd0);
      check("midload_rst_waddr", imem_waddr, 32'd0);
      check("midload_rst_wdata", imem_wdata, 32'd0);
      check("midload_rst_run", 32'(cpu_run), 32'd0);
      check("midload_rst_busy", 32'(busy), 32'd0);
      check("midload_rst_err", 32'(err), 32'd0);
      step(2);
      @(negedge clk) rst_n = 1'b1;
      step(2);
      run_load("reload", 16'd2, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
